// File: rtl/sram_port_ctrl_pkg.sv
// Shared types for the SRAM port controller: FSM states, the strobe bundle and
// the lane-split helper used to size the SRAM word address.
package sram_port_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_HOLD   = 3'd3,
        S_TURN   = 3'd4
    } state_e;

    // Active-low SRAM strobes travel as one bundle so idle/reset is a single constant.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '1;

    localparam int   CNT_W   = 4;
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Number of CPU address bits consumed by byte-lane selection (1 when the
    // CPU is half the SRAM width, else 0).
    function automatic int lane_bits(input int data_w, input int dq_w);
        return (data_w * 2 == dq_w) ? 1 : 0;
    endfunction

endpackage

// File: rtl/sram_port_ctrl_byte_lane_mux.sv
// Combinational byte-lane steering between the CPU data width and the SRAM DQ
// bus: write replication, read lane select and UB/LB lane-enable decode.
module sram_port_ctrl_byte_lane_mux
    import sram_port_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int SRAM_DQ_W = 16
) (
    input  logic                 addr_lsb_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [SRAM_DQ_W-1:0] dq_i,
    output logic [SRAM_DQ_W-1:0] dq_o,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 ub_sel_o,
    output logic                 lb_sel_o
);

    localparam int NUM_LANES = SRAM_DQ_W / DATA_W;

    logic [NUM_LANES-1:0][DATA_W-1:0] lanes_in;

    generate
        if (!(DATA_W == SRAM_DQ_W || DATA_W * 2 == SRAM_DQ_W)) begin : g_bad_ratio
            $error("sram_port_ctrl: DATA_W must equal SRAM_DQ_W or SRAM_DQ_W/2");
        end

        // Write data is replicated on every lane; only the strobed lane is stored.
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign dq_o[l*DATA_W +: DATA_W] = wdata_i;
            assign lanes_in[l]              = dq_i[l*DATA_W +: DATA_W];
        end

        if (NUM_LANES == 2) begin : g_split
            assign rdata_o  = lanes_in[addr_lsb_i];
            assign lb_sel_o = (addr_lsb_i == LANE_LO);
            assign ub_sel_o = (addr_lsb_i == LANE_HI);
        end else begin : g_full
            logic lsb_unused;
            assign lsb_unused = addr_lsb_i;
            assign rdata_o    = lanes_in[0];
            assign lb_sel_o   = 1'b1;
            assign ub_sel_o   = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/sram_port_ctrl.sv
// Request/ack controller for an asynchronous SRAM: sequences CE/OE/WE with
// programmable wait states and turnaround, owns the DQ tri-state and a debug capture.
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int SRAM_DQ_W   = 16,
    parameter int WAIT_STATES = 1,
    parameter int TURNAROUND  = 1,
    localparam int LB         = lane_bits(DATA_W, SRAM_DQ_W)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 ack_o,
    output logic                 busy_o,
    output logic [ADDR_W-LB-1:0] sram_addr_o,
    inout  wire  [SRAM_DQ_W-1:0] sram_dq_io,
    output logic                 sram_ce_n_o,
    output logic                 sram_oe_n_o,
    output logic                 sram_we_n_o,
    output logic                 sram_ub_n_o,
    output logic                 sram_lb_n_o,
    output logic [ADDR_W-1:0]    dbg_addr_o,
    output logic [DATA_W-1:0]    dbg_data_o,
    output logic                 dbg_we_o
);

    localparam logic [CNT_W-1:0] WS_CNT   = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] TURN_CNT = (TURNAROUND > 0) ? CNT_W'(TURNAROUND - 1) : '0;

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
            $error("sram_port_ctrl: WAIT_STATES must be 0..15");
        end
        if (TURNAROUND < 0 || TURNAROUND > 3) begin : g_bad_turn
            $error("sram_port_ctrl: TURNAROUND must be 0..3");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [ADDR_W-LB-1:0] sram_addr_q, sram_addr_d;
    strobes_t             strb_q, strb_d;
    logic                 dq_oe_q, dq_oe_d;
    logic [SRAM_DQ_W-1:0] dq_out_q, dq_out_d;
    logic [ADDR_W-1:0]    dbg_addr_q, dbg_addr_d;
    logic [DATA_W-1:0]    dbg_data_q, dbg_data_d;
    logic                 dbg_we_q, dbg_we_d;

    logic [SRAM_DQ_W-1:0] mux_dq;
    logic [DATA_W-1:0]    mux_rdata;
    logic                 ub_sel, lb_sel;
    logic                 active_d;

    // Driven from the next-cycle request so lane strobes register alongside CE.
    sram_port_ctrl_byte_lane_mux #(
        .DATA_W    (DATA_W),
        .SRAM_DQ_W (SRAM_DQ_W)
    ) u_lane_mux (
        .addr_lsb_i (addr_d[0]),
        .wdata_i    (wdata_d),
        .dq_i       (sram_dq_io),
        .dq_o       (mux_dq),
        .rdata_o    (mux_rdata),
        .ub_sel_o   (ub_sel),
        .lb_sel_o   (lb_sel)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        dbg_addr_d = dbg_addr_q;
        dbg_data_d = dbg_data_q;
        dbg_we_d   = dbg_we_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = S_SETUP;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = WS_CNT;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    if (!we_q) rdata_d = mux_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                dbg_addr_d = addr_q;
                dbg_we_d   = we_q;
                dbg_data_d = we_q ? wdata_q : rdata_q;
                if (TURNAROUND > 0) begin
                    state_d = S_TURN;
                    cnt_d   = TURN_CNT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so pins never glitch.
    always_comb begin
        active_d    = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_HOLD);
        strb_d      = STROBES_IDLE;
        strb_d.ce_n = !active_d;
        strb_d.ub_n = !(active_d && ub_sel);
        strb_d.lb_n = !(active_d && lb_sel);
        strb_d.oe_n = !(!we_d && ((state_d == S_SETUP) || (state_d == S_ACCESS)));
        strb_d.we_n = !(we_d && (state_d == S_ACCESS));
        dq_oe_d     = we_d && active_d;
        dq_out_d    = mux_dq;
        ack_d       = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
        sram_addr_d = addr_d[ADDR_W-1:LB];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= '0;
            strb_q      <= STROBES_IDLE;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
            dbg_addr_q  <= '0;
            dbg_data_q  <= '0;
            dbg_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            sram_addr_q <= sram_addr_d;
            strb_q      <= strb_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_data_q  <= dbg_data_d;
            dbg_we_q    <= dbg_we_d;
        end
    end

    assign sram_dq_io  = dq_oe_q ? dq_out_q : {SRAM_DQ_W{1'bz}};
    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign busy_o      = busy_q;
    assign sram_addr_o = sram_addr_q;
    assign sram_ce_n_o = strb_q.ce_n;
    assign sram_oe_n_o = strb_q.oe_n;
    assign sram_we_n_o = strb_q.we_n;
    assign sram_ub_n_o = strb_q.ub_n;
    assign sram_lb_n_o = strb_q.lb_n;
    assign dbg_addr_o  = dbg_addr_q;
    assign dbg_data_o  = dbg_data_q;
    assign dbg_we_o    = dbg_we_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: a split-lane instance (WS=1, TURN=2) and a
// full-width instance (WS=0, TURN=0), each against a behavioural SRAM.
module tb_sram_port_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: 8-bit CPU on 16-bit SRAM ----------------
    logic        a_req = 0, a_we = 0;
    logic [15:0] a_addr = '0;
    logic [7:0]  a_wdata = '0, a_rdata, a_dbg_data;
    logic        a_ack, a_busy, a_ce, a_oe, a_wen, a_ub, a_lb, a_dbg_we;
    logic [14:0] a_saddr;
    logic [15:0] a_dbg_addr;
    wire  [15:0] a_dq;

    sram_port_ctrl #(.ADDR_W(16), .DATA_W(8), .SRAM_DQ_W(16), .WAIT_STATES(1), .TURNAROUND(2)) u_a (
        .clk_i(clk), .reset_n_i(reset_n), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
        .wdata_i(a_wdata), .rdata_o(a_rdata), .ack_o(a_ack), .busy_o(a_busy),
        .sram_addr_o(a_saddr), .sram_dq_io(a_dq), .sram_ce_n_o(a_ce), .sram_oe_n_o(a_oe),
        .sram_we_n_o(a_wen), .sram_ub_n_o(a_ub), .sram_lb_n_o(a_lb),
        .dbg_addr_o(a_dbg_addr), .dbg_data_o(a_dbg_data), .dbg_we_o(a_dbg_we));

    logic [15:0] memA [0:32767];
    assign a_dq = (!a_ce && !a_oe && a_wen) ? memA[a_saddr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!a_ce && !a_wen && !a_lb) memA[a_saddr][7:0]  <= a_dq[7:0];
        if (!a_ce && !a_wen && !a_ub) memA[a_saddr][15:8] <= a_dq[15:8];
    end

    // ---------------- instance B: 16-bit CPU on 16-bit SRAM ----------------
    logic        b_req = 0, b_we = 0;
    logic [15:0] b_addr = '0, b_wdata = '0, b_rdata, b_dbg_data, b_dbg_addr, b_saddr;
    logic        b_ack, b_busy, b_ce, b_oe, b_wen, b_ub, b_lb, b_dbg_we;
    wire  [15:0] b_dq;

    sram_port_ctrl #(.ADDR_W(16), .DATA_W(16), .SRAM_DQ_W(16), .WAIT_STATES(0), .TURNAROUND(0)) u_b (
        .clk_i(clk), .reset_n_i(reset_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
        .wdata_i(b_wdata), .rdata_o(b_rdata), .ack_o(b_ack), .busy_o(b_busy),
        .sram_addr_o(b_saddr), .sram_dq_io(b_dq), .sram_ce_n_o(b_ce), .sram_oe_n_o(b_oe),
        .sram_we_n_o(b_wen), .sram_ub_n_o(b_ub), .sram_lb_n_o(b_lb),
        .dbg_addr_o(b_dbg_addr), .dbg_data_o(b_dbg_data), .dbg_we_o(b_dbg_we));

    logic [15:0] memB [0:65535];
    assign b_dq = (!b_ce && !b_oe && b_wen) ? memB[b_saddr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!b_ce && !b_wen && !b_lb) memB[b_saddr][7:0]  <= b_dq[7:0];
        if (!b_ce && !b_wen && !b_ub) memB[b_saddr][15:8] <= b_dq[15:8];
    end

    // Reference model: plain byte/word memories addressed by CPU address.
    logic [7:0]  refA [0:255];
    logic [15:0] refB [0:255];

    // Bus observers, sampled mid-cycle.
    int          run_a = 0, we_low_a = 0, acks_a = 0, ack_last_a = 0, ack_prev_a = 0, ovl_a = 0;
    logic [15:0] wr_dq_a = '0;
    logic [1:0]  lanes_a = '0;
    logic [14:0] saddr_a = '0;
    int          acks_b = 0, ack_last_b = 0, ack_prev_b = 0, ovl_b = 0;

    always @(negedge clk) begin
        if (!a_wen) run_a <= run_a + 1;
        else if (run_a != 0) begin we_low_a <= run_a; run_a <= 0; end
        if (!a_wen) wr_dq_a <= a_dq;
        if (!a_ce) begin lanes_a <= {a_ub, a_lb}; saddr_a <= a_saddr; end
        if (a_ack) begin acks_a <= acks_a + 1; ack_prev_a <= ack_last_a; ack_last_a <= cyc; end
        if ((!a_oe && !a_wen) || (a_ce && !(a_oe && a_wen && a_ub && a_lb)) ||
            (!a_oe && a_dq !== memA[a_saddr])) ovl_a <= ovl_a + 1;
        if (b_ack) begin acks_b <= acks_b + 1; ack_prev_b <= ack_last_b; ack_last_b <= cyc; end
        if ((!b_oe && !b_wen) || (!b_ce && (b_ub || b_lb)) || (b_ce && !(b_oe && b_wen)))
            ovl_b <= ovl_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (a_busy && n < 50) begin @(negedge clk); n++; end
        chk("a_idle_wait", 32'(n < 50), 1);
    endtask

    // One complete transfer on A with every externally visible effect checked.
    task automatic xfer_a(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        int n = 0;
        logic [7:0] exp;
        wait_idle_a();
        a_req = 1; a_we = we; a_addr = addr; a_wdata = wd;
        do begin @(negedge clk); n++; end while (!a_ack && n < 20);
        a_req = 0;
        chk("a_ack_latency", n, 4);
        chk("a_busy_in_ack", a_busy, 1);
        if (we) refA[addr[7:0]] = wd;
        exp = refA[addr[7:0]];
        if (!we) chk("a_rdata", a_rdata, exp);
        @(negedge clk);
        chk("a_ack_pulse", a_ack, 0);
        chk("a_dbg_addr", a_dbg_addr, addr);
        chk("a_dbg_data", a_dbg_data, exp);
        chk("a_dbg_we", a_dbg_we, we);
        chk("a_sram_addr", saddr_a, addr[15:1]);
        chk("a_lanes", lanes_a, addr[0] ? 2'b01 : 2'b10);
        if (we) begin
            chk("a_we_low_cycles", we_low_a, 2);
            chk("a_write_dq", wr_dq_a, {wd, wd});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] w;
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_strobes_a", {a_ce, a_oe, a_wen, a_ub, a_lb}, 5'b11111);
        chk("rst_ack_busy_a", {a_ack, a_busy}, 2'b00);
        chk("rst_regs_a", {a_rdata, a_saddr, a_dbg_addr, a_dbg_data, a_dbg_we}, '0);
        chk("rst_strobes_b", {b_ce, b_oe, b_wen, b_ub, b_lb, b_ack, b_busy}, 7'b1111100);
        reset_n = 1;
        @(negedge clk);

        // Lane steering and strobe timing on the split instance
        xfer_a(1, 16'h1234, 8'hC3);
        xfer_a(1, 16'h1235, 8'hA5);
        chk("a_mem_lane_mask", memA[15'h091A], 16'hA5C3);
        xfer_a(1, 16'h1235, 8'h5A);
        chk("a_mem_word", memA[15'h091A], 16'h5AC3);
        xfer_a(0, 16'h1234, 8'h00);
        xfer_a(0, 16'h1235, 8'h00);

        // req held high: transfers every WS+4+TURN = 7 cycles
        wait_idle_a();
        a_req = 1; a_we = 1; a_addr = 16'h1240; a_wdata = 8'h3C; refA[8'h40] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!a_ack && n < 30);
            chk("a_b2b_ack", a_ack, 1);
            if (!a_we) chk("a_b2b_rdata", a_rdata, refA[a_addr[7:0]]);
            case (i)
                0: begin a_we = 0; end
                1: begin a_we = 1; a_addr = 16'h1241; a_wdata = 8'h96; refA[8'h41] = 8'h96; end
                2: begin a_we = 0; end
                default: a_req = 0;
            endcase
            @(negedge clk);
            if (i > 0) chk("a_b2b_spacing", ack_last_a - ack_prev_a, 7);
        end

        // A req pulse while busy must not start a second transfer
        wait_idle_a();
        n = acks_a;
        a_req = 1; a_we = 0; a_addr = 16'h1234;
        @(negedge clk); a_req = 0;
        @(negedge clk); a_req = 1;
        @(negedge clk); a_req = 0;
        repeat (15) @(negedge clk);
        chk("a_pulse_one_ack", acks_a - n, 1);
        chk("a_pulse_idle", a_busy, 0);

        // Reset asserted in the middle of a write ACCESS
        wait_idle_a();
        a_req = 1; a_we = 1; a_addr = 16'h1300; a_wdata = 8'h77;
        @(negedge clk); a_req = 0;
        @(negedge clk);
        chk("a_mid_write_we", a_wen, 0);
        #2 reset_n = 0;
        #1;
        chk("a_rst_mid_strobes", {a_ce, a_oe, a_wen, a_ub, a_lb}, 5'b11111);
        chk("a_rst_mid_ack_busy", {a_ack, a_busy}, 2'b00);
        @(negedge clk); reset_n = 1;
        @(negedge clk);
        chk("a_post_rst_idle", {a_busy, a_ce, a_dbg_addr}, {1'b0, 1'b1, 16'h0000});
        xfer_a(0, 16'h1234, 8'h00);

        // Randomized traffic inside a 16-byte window
        for (int i = 0; i < 16; i++) xfer_a(1, 16'h1230 + 16'(i), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 24; i++)
            xfer_a(1'($urandom_range(0, 1)), 16'h1230 + 16'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)));
        chk("a_bus_protocol", ovl_a, 0);

        // Full-width instance, WS=0/TURN=0: one transfer every 4 cycles
        b_req = 1;
        for (int i = 0; i < 6; i++) begin
            b_we = (i < 3);
            b_addr = 16'h0100 + 16'(i % 3);
            b_wdata = 16'($urandom_range(0, 65535));
            if (b_we) refB[b_addr[7:0]] = b_wdata;
            w = refB[b_addr[7:0]];
            n = 0;
            do begin @(negedge clk); n++; end while (!b_ack && n < 20);
            chk("b_ack", b_ack, 1);
            if (i == 0) chk("b_first_latency", n, 3);
            if (!b_we) chk("b_rdata", b_rdata, w);
            if (i == 5) b_req = 0;
            @(negedge clk);
            if (i > 0) chk("b_spacing", ack_last_b - ack_prev_b, 4);
            chk("b_dbg", {b_dbg_addr, b_dbg_data, b_dbg_we}, {b_addr, w, b_we});
        end
        chk("b_mem_word", memB[16'h0102], refB[8'h02]);
        chk("b_bus_protocol", ovl_b, 0);
        chk("b_ack_total", acks_b, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
